gemm_sched: RTL and testbench
=============================

# gemm_sched

Issue scheduler between the matrix-instruction dispatch stage and the GEMM functional unit/systolic array. Buffers up to QDEPTH GEMM requests in order, holds each at the head until its source matrix registers are free of RAW hazards against in-flight GEMMs, and then presents it to the array. It also tracks which matrix register is currently loaded as the array's weight, and raises `gemm_new_weight` only when a reload is required.

## Interface
- QDEPTH, 4: request FIFO depth; must be a power of 2, ≥2.
- MAXF, 2: maximum number of GEMMs in flight in the array.
- REG_W, 4: matrix-register index width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  1  dispatch presents a GEMM.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rd, req_rs1, req_rs2, req_rs3  in  REG_W each  dest, A, weight (B), accumulator (C) matrix registers.
- gemm_valid  out  1  head op is issuable.
- gemm_ready  in  1  array accepts; issue = gemm_valid && gemm_ready.
- gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3  out  REG_W each  head op fields.
- gemm_new_weight  out  1  array must load weights from gemm_rs2.
- gemm_done  in  1  one-cycle pulse; oldest in-flight GEMM has completed.
- wb_valid, wb_rd  in  1, REG_W  a matrix load writes register wb_rd.
- flush  in  1  one-cycle pulse; drop queued (not in-flight) requests.
- busy  out  1  queue non-empty or any op in flight.
- count  out  $clog2(QDEPTH)+1  queued entries.
- err  out  1  sticky; set by gemm_done with nothing in flight.

## Operation
- FIFO is registered, with no bypass. An entry accepted at edge t is at the head from cycle t+1.
- In-flight table is an ordered list of up to MAXF destination indices. An issue appends gemm_rd. A gemm_done pulse retires the oldest entry.
- Hazard: the head is blocked if rs1, rs2 or rs3 equals any in-flight rd. The check uses the registered table, so an entry retiring this cycle still blocks.
- The head is also blocked when the in-flight count equals MAXF.
- gemm_valid = (state==ACTIVE) && count>0 && !hazard && !inflight_full.
- Weight tracking uses registers wreg (REG_W) and wvalid.
  - gemm_new_weight = !wvalid || (gemm_rs2 != wreg).
  - On issue: wreg <= gemm_rs2 and wvalid <= 1.
  - wvalid is cleared if the issued rd == gemm_rs2, or if wb_valid && wb_rd == wreg. A clear takes priority over a same-cycle set.
- FSM:
  - IDLE: moves to ACTIVE on request accept.
  - ACTIVE: moves to IDLE when the queue is empty and nothing is in flight (evaluated on post-update state). On flush it moves to DRAIN.
  - DRAIN: the queue is cleared at the flush edge, and req_ready and gemm_valid are 0. It moves to IDLE once the in-flight count reaches 0.
  - A flush in IDLE clears nothing and stays in IDLE.
- req_ready = (count < QDEPTH) && state != DRAIN. There is no same-cycle enqueue-into-full, even if the head issues that cycle.
- Simultaneous enqueue and issue: count is unchanged. Simultaneous issue and gemm_done: in-flight count is unchanged and the table shifts, then appends.
- A gemm_done pulse with in-flight count 0 sets err and is otherwise ignored.
- Pointers wrap modulo QDEPTH.
- A flush coincident with req_valid does not accept the request.
- busy = count!=0 || inflight!=0.

## Timing
- Reset values: count=0, pointers=0, in-flight=0, wvalid=0, wreg=0, err=0, state=IDLE.
- Resulting output values at reset: req_ready=1, gemm_valid=0, gemm_new_weight=1, busy=0, gemm_* fields=0.
- RST asserted mid-operation discards the queue and in-flight tracking at that edge. Any later gemm_done before a new issue sets err.
- Accept-to-issue latency is 1 cycle minimum (accept at t, gemm_valid at t+1).
- gemm_done at edge t unblocks a dependent head at t+1, so it can issue at edge t+1.
- Outputs are combinational from registers only. There is no combinational path from gemm_ready or req_valid to any output.
- gemm_* fields are stable while gemm_valid && !gemm_ready.

## Test plan
- Reset, then back-to-back issue: after reset, enqueue {rd=1,rs1=2,rs2=3,rs3=0} and {rd=4,rs1=5,rs2=3,rs3=0} with gemm_ready=1.
  - Issues occur at cycles 1 and 2.
  - new_weight is 1 for the first and 0 for the second.
  - busy stays 1 until two gemm_done pulses.
- RAW stall: issue op {rd=6}, then queue {rs1=6}.
  - gemm_valid stays 0 until the cycle after gemm_done, then issues.
- MAXF and full queue: hold gemm_done low.
  - The third GEMM blocks.
  - Enqueue 4 more; req_ready=0 with count=4.
  - One gemm_done lets the next issue. req_ready returns only after a dequeue.
- Weight invalidation: after an issue with rs2=3, pulse wb_valid with wb_rd=3.
  - The next head with rs2=3 shows new_weight=1.
  - A separate op with rd equal to its own rs2 also forces new_weight=1 on the next op.
- Flush and drain: with 3 queued and 2 in flight, pulse flush.
  - count=0 and req_ready=0 next cycle.
  - IDLE is reached only after 2 gemm_done pulses.
  - A spurious third gemm_done sets err=1.
- Mid-op reset: with 2 queued and 1 in flight, assert RST.
  - All outputs return to their reset values next cycle.

Source files
------------

// File: rtl/gemm_sched.sv
`default_nettype none
// ============================================================================
// Module   : gemm_sched
// Purpose  : In-order GEMM issue queue with RAW hazard blocking against
//            in-flight destinations and array weight-reuse tracking.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_sched #(
    parameter int QDEPTH = 4,
    parameter int MAXF   = 2,
    parameter int REG_W  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [REG_W-1:0]          req_rd,
    input  logic [REG_W-1:0]          req_rs1,
    input  logic [REG_W-1:0]          req_rs2,
    input  logic [REG_W-1:0]          req_rs3,
    output logic                      gemm_valid,
    input  logic                      gemm_ready,
    output logic [REG_W-1:0]          gemm_rd,
    output logic [REG_W-1:0]          gemm_rs1,
    output logic [REG_W-1:0]          gemm_rs2,
    output logic [REG_W-1:0]          gemm_rs3,
    output logic                      gemm_new_weight,
    input  logic                      gemm_done,
    input  logic                      wb_valid,
    input  logic [REG_W-1:0]          wb_rd,
    input  logic                      flush,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   count,
    output logic                      err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MAXF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [REG_W-1:0] r_q_rd  [QDEPTH];
    logic [REG_W-1:0] r_q_rs1 [QDEPTH];
    logic [REG_W-1:0] r_q_rs2 [QDEPTH];
    logic [REG_W-1:0] r_q_rs3 [QDEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;

    logic [REG_W-1:0] r_inf_rd     [MAXF];
    logic [REG_W-1:0] w_inf_rd_nxt [MAXF];
    logic [IW-1:0]    r_inf_cnt;
    logic [IW-1:0]    w_inf_cnt_nxt;

    logic [REG_W-1:0] r_wreg;
    logic             r_wvalid;
    logic             r_err;

    logic             w_hazard;
    logic             w_inf_full;
    logic             w_accept;
    logic             w_issue;
    logic             w_retire;
    logic             w_flush_q;
    logic             w_wclear;

    assign gemm_rd   = r_q_rd[r_rptr];
    assign gemm_rs1  = r_q_rs1[r_rptr];
    assign gemm_rs2  = r_q_rs2[r_rptr];
    assign gemm_rs3  = r_q_rs3[r_rptr];

    // Registered table only: an op retiring this cycle still blocks its readers.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < MAXF; i++) begin
            if ((IW'(i) < r_inf_cnt) &&
                ((r_inf_rd[i] == gemm_rs1) || (r_inf_rd[i] == gemm_rs2) ||
                 (r_inf_rd[i] == gemm_rs3))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_inf_full      = (r_inf_cnt == IW'(MAXF));
    assign gemm_valid      = (r_state == ST_ACTIVE) && (r_count != '0) &&
                             !w_hazard && !w_inf_full;
    assign req_ready       = (r_count < CW'(QDEPTH)) && (r_state != ST_DRAIN);
    assign gemm_new_weight = !r_wvalid || (gemm_rs2 != r_wreg);
    assign busy            = (r_count != '0) || (r_inf_cnt != '0);
    assign count           = r_count;
    assign err             = r_err;

    assign w_accept  = req_valid && req_ready && !flush;
    assign w_issue   = gemm_valid && gemm_ready;
    assign w_retire  = gemm_done && (r_inf_cnt != '0);
    assign w_flush_q = flush && (r_state == ST_ACTIVE);
    assign w_wclear  = (w_issue && (gemm_rd == gemm_rs2)) ||
                       (wb_valid && (wb_rd == r_wreg));

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush_q) begin
            w_count_nxt = '0;
        end else if (w_accept && !w_issue) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_accept && w_issue) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Retire shifts the oldest out first, then an issue appends at the new tail.
    always_comb begin
        w_inf_rd_nxt  = r_inf_rd;
        w_inf_cnt_nxt = r_inf_cnt;
        if (w_retire) begin
            for (int i = 0; i < MAXF - 1; i++) begin
                w_inf_rd_nxt[i] = r_inf_rd[i+1];
            end
            w_inf_rd_nxt[MAXF-1] = '0;
            w_inf_cnt_nxt        = r_inf_cnt - 1'b1;
        end
        if (w_issue) begin
            for (int i = 0; i < MAXF; i++) begin
                if (IW'(i) == w_inf_cnt_nxt) begin
                    w_inf_rd_nxt[i] = gemm_rd;
                end
            end
            w_inf_cnt_nxt = w_inf_cnt_nxt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else if ((w_count_nxt == '0) && (w_inf_cnt_nxt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_inf_cnt_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_rd[i]  <= '0;
                r_q_rs1[i] <= '0;
                r_q_rs2[i] <= '0;
                r_q_rs3[i] <= '0;
            end
            for (int i = 0; i < MAXF; i++) begin
                r_inf_rd[i] <= '0;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_inf_cnt <= '0;
            r_wreg    <= '0;
            r_wvalid  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_inf_rd  <= w_inf_rd_nxt;
            r_inf_cnt <= w_inf_cnt_nxt;
            if (w_flush_q) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_accept) begin
                    r_q_rd[r_wptr]  <= req_rd;
                    r_q_rs1[r_wptr] <= req_rs1;
                    r_q_rs2[r_wptr] <= req_rs2;
                    r_q_rs3[r_wptr] <= req_rs3;
                    r_wptr          <= r_wptr + 1'b1;
                end
                if (w_issue) begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
            if (w_issue) begin
                r_wreg <= gemm_rs2;
            end
            // Invalidation wins over a same-cycle reload.
            if (w_wclear) begin
                r_wvalid <= 1'b0;
            end else if (w_issue) begin
                r_wvalid <= 1'b1;
            end
            if (gemm_done && (r_inf_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_sched
// Purpose  : Directed scoreboard bench for gemm_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_sched;

    localparam int QDEPTH = 4;
    localparam int MAXF   = 2;
    localparam int REG_W  = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             req_valid, req_ready;
    logic [REG_W-1:0] req_rd, req_rs1, req_rs2, req_rs3;
    logic             gemm_valid, gemm_ready;
    logic [REG_W-1:0] gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3;
    logic             gemm_new_weight, gemm_done, wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             flush, busy, err;
    logic [2:0]       count;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs3;
        logic             nw;
    } op_t;

    op_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    gemm_sched #(.QDEPTH(QDEPTH), .MAXF(MAXF), .REG_W(REG_W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
        .gemm_rd(gemm_rd), .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3),
        .gemm_new_weight(gemm_new_weight), .gemm_done(gemm_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .count(count), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every issue handshake pops the next expected op.
    always @(negedge CLK) begin
        op_t a;
        op_t e;
        if (!RST && gemm_valid && gemm_ready) begin
            a = '{rd: gemm_rd, rs1: gemm_rs1, rs2: gemm_rs2, rs3: gemm_rs3, nw: gemm_new_weight};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_unexpected: got 0x%0h expected none", a);
            end else begin
                e = sb.pop_front();
                chk("issue_op", 32'(a), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [3:0] rs3);
        req_rd  = rd;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_rs3 = rs3;
    endtask

    task automatic expect_op(input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [3:0] rs2, input logic [3:0] rs3, input logic nw);
        sb.push_back('{rd: rd, rs1: rs1, rs2: rs2, rs3: rs3, nw: nw});
    endtask

    task automatic done_pulse();
        gemm_done = 1'b1;
        tick();
        gemm_done = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_gemm_valid"}, 32'(gemm_valid), 32'd0);
        chk({tag, "_new_weight"}, 32'(gemm_new_weight), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_fields"}, 32'({gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3}), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0; gemm_ready = 1'b0; gemm_done = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        set_req(0, 0, 0, 0);
        tick();
        tick();
        RST = 1'b0;
        chk_reset("rst");

        // Back-to-back issue; second op reuses the loaded weight.
        gemm_ready = 1'b1;
        expect_op(1, 2, 3, 0, 1'b1);
        expect_op(4, 5, 3, 0, 1'b0);
        req_valid = 1'b1; set_req(1, 2, 3, 0);
        tick();
        chk("lat1_valid", 32'(gemm_valid), 32'd1);
        set_req(4, 5, 3, 0);
        tick();
        req_valid = 1'b0;
        chk("b2b_count", 32'(count), 32'd1);
        chk("b2b_valid", 32'(gemm_valid), 32'd1);
        tick();
        gemm_ready = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_qempty", 32'(count), 32'd0);
        done_pulse();
        chk("b2b_busy1", 32'(busy), 32'd1);
        done_pulse();
        chk("b2b_idle", 32'(busy), 32'd0);

        // RAW stall on rd=6.
        gemm_ready = 1'b1;
        expect_op(6, 1, 2, 0, 1'b1);
        expect_op(7, 6, 2, 0, 1'b0);
        req_valid = 1'b1; set_req(6, 1, 2, 0);
        tick();
        set_req(7, 6, 2, 0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall", 32'(gemm_valid), 32'd0);
            tick();
        end
        gemm_done = 1'b1;
        #1;
        chk("raw_retire_cycle", 32'(gemm_valid), 32'd0);
        tick();
        gemm_done = 1'b0;
        chk("raw_unblock", 32'(gemm_valid), 32'd1);
        tick();
        done_pulse();
        chk("raw_idle", 32'(busy), 32'd0);

        // MAXF blocking and full queue.
        expect_op(8, 1, 2, 0, 1'b0);
        expect_op(9, 1, 5, 0, 1'b1);
        expect_op(10, 1, 5, 0, 1'b0);
        req_valid = 1'b1; set_req(8, 1, 2, 0);
        tick();
        set_req(9, 1, 5, 0);
        tick();
        set_req(10, 1, 5, 0);
        tick();
        chk("maxf_block", 32'(gemm_valid), 32'd0);
        chk("maxf_count", 32'(count), 32'd1);
        set_req(11, 1, 5, 0); tick();
        set_req(12, 1, 5, 0); tick();
        set_req(13, 1, 5, 0); tick();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        set_req(14, 1, 5, 0);
        tick();
        chk("full_noacc", 32'(count), 32'd4);
        done_pulse();
        chk("full_ready_after_done", 32'(req_ready), 32'd0);
        chk("maxf_unblock", 32'(gemm_valid), 32'd1);
        tick();
        chk("deq_ready", 32'(req_ready), 32'd1);
        chk("deq_count", 32'(count), 32'd3);
        tick();
        req_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        for (int r = 11; r <= 14; r++) expect_op(4'(r), 1, 5, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            tick();
        end
        done_pulse();
        done_pulse();
        chk("maxf_idle", 32'(busy), 32'd0);

        // Weight invalidation by a matrix load.
        expect_op(1, 2, 3, 0, 1'b1);
        expect_op(2, 4, 3, 0, 1'b1);
        req_valid = 1'b1; set_req(1, 2, 3, 0);
        tick();
        req_valid = 1'b0;
        tick();
        wb_valid = 1'b1; wb_rd = 4'd3;
        tick();
        wb_valid = 1'b0;
        req_valid = 1'b1; set_req(2, 4, 3, 0);
        tick();
        req_valid = 1'b0;
        tick();
        done_pulse();
        done_pulse();

        // Weight invalidation by an op overwriting its own weight register.
        expect_op(3, 0, 3, 0, 1'b0);
        expect_op(4, 0, 3, 0, 1'b1);
        req_valid = 1'b1; set_req(3, 0, 3, 0);
        tick();
        set_req(4, 0, 3, 0);
        tick();
        req_valid = 1'b0;
        chk("self_hazard", 32'(gemm_valid), 32'd0);
        chk("self_nw", 32'(gemm_new_weight), 32'd1);
        done_pulse();
        tick();
        done_pulse();
        chk("wt_idle", 32'(busy), 32'd0);

        // Flush with 3 queued and 2 in flight.
        expect_op(5, 0, 1, 0, 1'b1);
        expect_op(6, 0, 1, 0, 1'b0);
        req_valid = 1'b1; set_req(5, 0, 1, 0);
        tick();
        set_req(6, 0, 1, 0); tick();
        set_req(7, 0, 1, 0); tick();
        set_req(8, 0, 1, 0); tick();
        set_req(9, 0, 1, 0); tick();
        chk("pre_flush_count", 32'(count), 32'd3);
        set_req(10, 0, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd0);
        chk("flush_valid", 32'(gemm_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        done_pulse();
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        done_pulse();
        chk("drain_busy0", 32'(busy), 32'd0);
        chk("drain_err0", 32'(err), 32'd0);
        tick();
        chk("drain_idle_ready", 32'(req_ready), 32'd1);
        done_pulse();
        chk("spurious_err", 32'(err), 32'd1);

        // Mid-op reset with 2 queued and 1 in flight.
        expect_op(1, 2, 3, 4, 1'b1);
        req_valid = 1'b1; set_req(1, 2, 3, 4);
        tick();
        set_req(5, 1, 0, 0); tick();
        set_req(6, 0, 0, 0); tick();
        req_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_hazard", 32'(gemm_valid), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset("midrst");
        done_pulse();
        chk("post_rst_err", 32'(err), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
